// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller
// Description : Control unit ahead of the datapath. Holds the PC and IR,
//               fetches 16-bit instructions from a registered instruction
//               ROM and decodes them through a Moore FSM that drives every
//               datapath control line.
//               Optional build macro CTRL_ILLEGAL_HALT_EN: when defined, an
//               illegal opcode halts the controller instead of acting as NOOP.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_controller #(
  parameter int PC_W = 7,
  parameter int IR_W = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [IR_W-1:0]   IM_Data,
  output logic [PC_W-1:0]   IM_Addr,
  output logic [7:0]        D_Addr,
  output logic              D_Wr,
  output logic              RF_s,
  output logic [3:0]        RF_W_Addr,
  output logic              RF_W_en,
  output logic [3:0]        RF_Ra_Addr,
  output logic [3:0]        RF_Rb_Addr,
  output logic [2:0]        ALU_s0,
  output logic [PC_W-1:0]   PC_out,
  output logic [IR_W-1:0]   IR_out,
  output logic [3:0]        State_out,
  output logic              Halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] c_OP_NOOP  = 4'h0;
  localparam logic [3:0] c_OP_LOAD  = 4'h1;
  localparam logic [3:0] c_OP_STORE = 4'h2;
  localparam logic [3:0] c_OP_ADD   = 4'h3;
  localparam logic [3:0] c_OP_SUB   = 4'h4;
  localparam logic [3:0] c_OP_HALT  = 4'h5;

  localparam logic [2:0] c_ALU_PASS = 3'b000;
  localparam logic [2:0] c_ALU_ADD  = 3'b001;
  localparam logic [2:0] c_ALU_SUB  = 3'b010;

  state_t            r_state;
  state_t            w_next_state;
  logic [PC_W-1:0]   r_pc;
  logic [IR_W-1:0]   r_ir;
  logic [3:0]        w_op;

  assign w_op      = r_ir[15:12];
  assign IM_Addr   = r_pc;
  assign PC_out    = r_pc;
  assign IR_out    = r_ir;
  assign State_out = r_state;

  // State register; reset drops straight to INIT from any state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the ROM word and advance the PC (wrapping) on the edge leaving FETCH.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_pc <= '0;
      r_ir <= '0;
    end else if (r_state == S_FETCH) begin
      r_ir <= IM_Data;
      r_pc <= r_pc + 1'b1;
    end
  end

  // Next-state logic: fetch/decode loop, LOAD takes two execute cycles.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INIT:   w_next_state = S_FETCH;
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        case (w_op)
          c_OP_NOOP:  w_next_state = S_NOOP;
          c_OP_LOAD:  w_next_state = S_LOAD_A;
          c_OP_STORE: w_next_state = S_STORE;
          c_OP_ADD:   w_next_state = S_ADD;
          c_OP_SUB:   w_next_state = S_SUB;
          c_OP_HALT:  w_next_state = S_HALT;
`ifdef CTRL_ILLEGAL_HALT_EN
          default:    w_next_state = S_HALT;
`else
          default:    w_next_state = S_NOOP;
`endif
        endcase
      end
      S_NOOP:   w_next_state = S_FETCH;
      S_LOAD_A: w_next_state = S_LOAD_B;
      S_LOAD_B: w_next_state = S_FETCH;
      S_STORE:  w_next_state = S_FETCH;
      S_ADD:    w_next_state = S_FETCH;
      S_SUB:    w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_INIT;
    endcase
  end

  // Moore outputs from state and IR; unused address fields are held at zero.
  always_comb begin
    D_Addr     = 8'h00;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = 4'h0;
    RF_W_en    = 1'b0;
    RF_Ra_Addr = 4'h0;
    RF_Rb_Addr = 4'h0;
    ALU_s0     = c_ALU_PASS;
    Halted     = 1'b0;
    case (r_state)
      S_LOAD_A: begin
        D_Addr = r_ir[11:4];
        RF_s   = 1'b1;
      end
      S_LOAD_B: begin
        D_Addr    = r_ir[11:4];
        RF_W_Addr = r_ir[3:0];
        RF_s      = 1'b1;
        RF_W_en   = 1'b1;
      end
      S_STORE: begin
        D_Addr     = r_ir[11:4];
        RF_Ra_Addr = r_ir[3:0];
        D_Wr       = 1'b1;
      end
      S_ADD: begin
        RF_Ra_Addr = r_ir[11:8];
        RF_Rb_Addr = r_ir[7:4];
        RF_W_Addr  = r_ir[3:0];
        ALU_s0     = c_ALU_ADD;
        RF_W_en    = 1'b1;
      end
      S_SUB: begin
        RF_Ra_Addr = r_ir[11:8];
        RF_Rb_Addr = r_ir[7:4];
        RF_W_Addr  = r_ir[3:0];
        ALU_s0     = c_ALU_SUB;
        RF_W_en    = 1'b1;
      end
      S_HALT:   Halted = 1'b1;
      default:  ;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Control unit that sits directly upstream of the processor datapath.
- Holds the program counter (PC) and instruction register (IR), and fetches 16-bit instructions from a synchronous instruction ROM.
- A Moore FSM decodes each instruction and drives every datapath control line: D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0.

Parameters:
- PC_W, 7, PC and instruction-ROM address width (128 words).
- IR_W, 16, instruction width. Fixed at 16; other values are unsupported.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- IM_Data  in  16  instruction ROM read data; registered ROM, valid one cycle after IM_Addr.
- IM_Addr  out  PC_W  instruction ROM address; equals PC at all times.
- D_Addr  out  8  data memory address.
- D_Wr  out  1  data memory write enable.
- RF_s  out  1  write-back mux select: 1 = data memory, 0 = ALU.
- RF_W_Addr  out  4  register file write address.
- RF_W_en  out  1  register file write enable.
- RF_Ra_Addr  out  4  register file A-side read address.
- RF_Rb_Addr  out  4  register file B-side read address.
- ALU_s0  out  3  ALU function: 3'b001 add, 3'b010 subtract, 3'b000 pass-through.
- PC_out  out  PC_W  current PC (debug).
- IR_out  out  16  current IR (debug).
- State_out  out  4  FSM state encoding (debug).
- Halted  out  1  high while in HALT.

Behaviour:
- Reset (asynchronous, Resetn=0):
  - State=INIT, PC=0, IR=16'h0000.
  - All enables (D_Wr, RF_W_en) = 0; RF_s=0; ALU_s0=3'b000; all address outputs = 0; Halted=0.
  - Reset asserted in any state, including mid-LOAD, aborts that state. No partial write is issued after the edge at which Resetn falls.
- Instruction fields:
  - op = IR[15:12].
  - NOOP 4'h0.
  - LOAD 4'h1: D_Addr=IR[11:4], RF_W_Addr=IR[3:0].
  - STORE 4'h2: D_Addr=IR[11:4], RF_Ra_Addr=IR[3:0].
  - ADD 4'h3 and SUB 4'h4: RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0].
  - HALT 4'h5.
  - Opcodes 4'h6..4'hF are illegal.
- State encoding: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
- State transitions and actions:
  - INIT -> FETCH unconditionally. Gives the ROM one cycle to present word 0.
  - FETCH: on the exiting edge, IR <= IM_Data and PC <= PC+1. Go to DECODE.
  - DECODE: route to the state for op (NOOP, LOAD_A, STORE, ADD, SUB, HALT). An illegal op goes to NOOP.
  - NOOP -> FETCH.
  - LOAD_A: D_Addr driven; RF_s=1; RF_W_en=0. Go to LOAD_B (waits out synchronous Dmem read latency).
  - LOAD_B: D_Addr and RF_W_Addr driven; RF_s=1; RF_W_en=1. Go to FETCH.
  - STORE: D_Addr and RF_Ra_Addr driven; D_Wr=1. Go to FETCH.
  - ADD: Ra, Rb and W addresses driven; ALU_s0=3'b001; RF_s=0; RF_W_en=1. Go to FETCH.
  - SUB: same as ADD with ALU_s0=3'b010.
  - HALT: Halted=1; stays in HALT until reset; no enables asserted.
- Output rules:
  - Outputs are Moore and depend only on state and IR.
  - In states that do not use a field, that address output is 0.
  - D_Wr and RF_W_en are never high in the same cycle.
- Instruction timing: PC is stable for at least 2 cycles before every FETCH, so IM_Data is always valid when sampled.
  - Cycles per instruction: NOOP/STORE/ADD/SUB = 3, LOAD = 4, HALT = 2 to enter.
- PC wraps from 2^PC_W-1 to 0 with no flag.

Optional Feature:
- Macro CTRL_ILLEGAL_HALT_EN.
- Defined: DECODE with an illegal opcode transitions to HALT, and Halted=1 from the next cycle.
- Undefined: an illegal opcode executes as NOOP and fetching continues.

Test Plan:
- Reset then ROM[0]=16'h1060 (LOAD D[6]->R0): D_Addr=8'h06 and RF_s=1 in LOAD_A; RF_W_en=1 and RF_W_Addr=0 only in LOAD_B; PC_out=1 after FETCH.
- ROM[1]=16'h3012 (ADD R0+R1->R2): ADD state shows Ra=0, Rb=1, RF_W_Addr=2, ALU_s0=3'b001, RF_s=0, RF_W_en=1 for exactly 1 cycle.
- ROM[2]=16'h2002 (STORE R2->D[0]): D_Wr=1 for 1 cycle, D_Addr=8'h00, RF_Ra_Addr=2, RF_W_en=0. Then ROM[3]=16'h4210 (SUB) gives ALU_s0=3'b010.
- ROM[4]=16'h5000: Halted=1 and held for 20 cycles; PC_out stays 5; D_Wr=RF_W_en=0 throughout.
- ROM[0]=16'hA000: with CTRL_ILLEGAL_HALT_EN defined -> HALT; without it -> NOOP, then FETCH of address 1.
- Deassert Resetn during LOAD_A: State_out=0, PC_out=0 and all enables 0 immediately (asynchronous); after release the first FETCH reads ROM[0].
